day_month_counter: RTL

Calendar stage that tracks day-of-month and month, advancing on a day tick from the time-of-day chain and handing a one-cycle month-roll pulse to `year_counter` (`carry_in_month`). It reads the current year back from `year_counter` so February length follows the full Gregorian leap rule over the clock's 2025–3025 range. It shares the `ctrl_set` / `inc` / `dec` manual-set controls with the rest of the calendar chain.

---
 rtl/calendar_pkg.sv | 42 ++++
 rtl/leap_year_detect.sv | 22 ++
 rtl/day_month_counter.sv | 100 ++++++++++
 3 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar definitions: field widths, month ids,
// year range and month-length helpers.
package calendar_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 12;

  localparam int BASE_YEAR = 2025;
  localparam int MAX_YEAR  = 3025;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  function automatic logic is_30_day(
    input logic [MONTH_W-1:0] m
  );
    return m inside {APR, JUN, SEP, NOV};
  endfunction

  function automatic logic [DAY_W-1:0] month_len(
    input logic [MONTH_W-1:0] m,
    input logic               leap
  );
    if (m == FEB)
      return leap ? 5'd29 : 5'd28;
    if (is_30_day(m))
      return 5'd30;
    return 5'd31;
  endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Gregorian leap-year test on a binary year:
// div by 4 and not by 100, or div by 400.
module leap_year_detect #(
  parameter int YEAR_W = 12
) (
  input  logic [YEAR_W-1:0] year_count,
  output logic              is_leap
);

  logic div4;
  logic div100;
  logic div400;

  // constant-divisor remainders feed the leap rule
  always_comb begin
    div4    = (year_count % YEAR_W'(4))   == '0;
    div100  = (year_count % YEAR_W'(100)) == '0;
    div400  = (year_count % YEAR_W'(400)) == '0;
    is_leap = (div4 && !div100) || div400;
  end

endmodule

// File: rtl/day_month_counter.sv
// Day-of-month / month stage of the calendar chain,
// with manual set and month-roll carry to the year stage.
module day_month_counter #(
  parameter int YEAR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carry_in_day,
  input  logic              ctrl_set,
  input  logic              field_sel,
  input  logic              inc,
  input  logic              dec,
  input  logic [YEAR_W-1:0] year_count,
  output logic [4:0]        day_count,
  output logic [3:0]        month_count,
  output logic [4:0]        days_in_month,
  output logic              carry_out_month
);

  import calendar_pkg::*;

  logic               is_leap;
  logic [DAY_W-1:0]   day_n;
  logic [MONTH_W-1:0] month_n;
  logic               carry_n;
  logic [MONTH_W-1:0] month_set;
  logic [DAY_W-1:0]   set_len;
  logic               set_step;

  leap_year_detect #(
    .YEAR_W (YEAR_W)
  ) u_leap (
    .year_count (year_count),
    .is_leap    (is_leap)
  );

  assign days_in_month = month_len(month_count, is_leap);
  assign set_step      = ctrl_set && (inc || dec);

  // month target of a manual step and its length
  always_comb begin
    month_set = month_count;
    if (inc)
      month_set = (month_count >= DEC) ? JAN
                : month_count + 4'd1;
    else
      month_set = (month_count <= JAN) ? DEC
                : month_count - 4'd1;
    set_len = month_len(month_set, is_leap);
  end

  // next state: set step, then day tick, then clamp
  always_comb begin
    day_n   = day_count;
    month_n = month_count;
    carry_n = 1'b0;
    if (set_step) begin
      if (!field_sel) begin
        if (inc)
          day_n = (day_count >= days_in_month) ? 5'd1
                : day_count + 5'd1;
        else
          day_n = (day_count <= 5'd1) ? days_in_month
                : day_count - 5'd1;
      end else begin
        month_n = month_set;
        day_n   = (day_count > set_len) ? set_len
                : day_count;
      end
    end else if (!ctrl_set && carry_in_day) begin
      if (day_count < days_in_month) begin
        day_n = day_count + 5'd1;
      end else begin
        day_n = 5'd1;
        if (month_count >= DEC) begin
          month_n = JAN;
          carry_n = 1'b1;
        end else begin
          month_n = month_count + 4'd1;
        end
      end
    end else if (day_count > days_in_month) begin
      day_n = days_in_month;
    end
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      day_count       <= 5'd1;
      month_count     <= JAN;
      carry_out_month <= 1'b0;
    end else begin
      day_count       <= day_n;
      month_count     <= month_n;
      carry_out_month <= carry_n;
    end
  end

endmodule
